expr_eval: RTL and testbench



---
 rtl/expr_eval.sv | 126 ++++++++++++
 tb/tb_expr_eval.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/expr_eval.sv
`default_nettype none
// ============================================================================
// Module   : expr_eval
// Purpose  : Streaming evaluator for single-digit '+'/'*' expressions.
//            '*' binds tighter than '+'. Reports completeness, value and
//            sticky error and overflow flags.
// Revision : 1.0  initial release
// ============================================================================
module expr_eval #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [7:0]       in,
  output logic             out,
  output logic [WIDTH-1:0] value,
  output logic             err,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NUM  = 2'd1,
    OPR  = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [WIDTH-1:0]   prod_q, prod_d;
  logic               mul_q, mul_d;
  logic [WIDTH-1:0]   value_q, value_d;
  logic               err_q, err_d;
  logic               ovf_q, ovf_d;

  logic               is_dig, is_plus, is_star;
  logic [WIDTH-1:0]   dig;
  logic [2*WIDTH-1:0] full_prod;
  logic               full_prod_ovf;
  logic [WIDTH-1:0]   prod_n;
  logic [WIDTH:0]     sum_ext;

  always_comb begin
    is_dig  = (in >= 8'h30) && (in <= 8'h39);
    is_plus = (in == 8'h2B);
    is_star = (in == 8'h2A);
    // For '0'..'9' the low nibble is exactly the digit value.
    dig     = WIDTH'(in[3:0]);

    full_prod     = {{WIDTH{1'b0}}, prod_q} * {{WIDTH{1'b0}}, dig};
    full_prod_ovf = |full_prod[2*WIDTH-1:WIDTH];
    prod_n        = ((state_q == OPR) && mul_q) ? full_prod[WIDTH-1:0] : dig;
    sum_ext       = {1'b0, sum_q} + {1'b0, prod_n};
  end

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    prod_d  = prod_q;
    mul_d   = mul_q;
    value_d = value_q;
    err_d   = err_q;
    ovf_d   = ovf_q;

    if (in_valid) begin
      case (state_q)
        IDLE, OPR: begin
          if (is_dig) begin
            state_d = NUM;
            prod_d  = prod_n;
            value_d = sum_ext[WIDTH-1:0];
            ovf_d   = ovf_q | sum_ext[WIDTH]
                    | ((state_q == OPR) && mul_q && full_prod_ovf);
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
        NUM: begin
          if (is_plus) begin
            state_d = OPR;
            sum_d   = sum_q + prod_q;
            mul_d   = 1'b0;
          end else if (is_star) begin
            state_d = OPR;
            mul_d   = 1'b1;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
        default: begin
          state_d = ERR;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      sum_q   <= '0;
      prod_q  <= '0;
      mul_q   <= 1'b0;
      value_q <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      prod_q  <= prod_d;
      mul_q   <= mul_d;
      value_q <= value_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out   = (state_q == NUM);
  assign value = value_q;
  assign err   = err_q;
  assign ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_expr_eval.sv
`default_nettype none
// ============================================================================
// Module   : tb_expr_eval
// Purpose  : Directed, table-driven self-checking bench for expr_eval (WIDTH=8).
// Revision : 1.0  initial release
// ============================================================================
module tb_expr_eval;

  localparam int W = 8;

  logic         clk;
  logic         clr;
  logic         in_valid;
  logic [7:0]   in;
  logic         out;
  logic [W-1:0] value;
  logic         err;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  expr_eval #(.WIDTH(W)) dut (
    .clk      (clk),
    .clr      (clr),
    .in_valid (in_valid),
    .in       (in),
    .out      (out),
    .value    (value),
    .err      (err),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         clr;
    logic         vld;
    logic [7:0]   ch;
    logic         e_out;
    logic [W-1:0] e_val;
    logic         e_err;
    logic         e_ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic c, input logic v, input logic [7:0] ch,
                     input logic eo, input int ev, input logic ee, input logic eov);
    vec_t r;
    r.clr = c; r.vld = v; r.ch = ch;
    r.e_out = eo; r.e_val = W'(ev); r.e_err = ee; r.e_ovf = eov;
    tbl.push_back(r);
  endtask

  // Drive one cycle, then compare all outputs 1 time unit after the edge.
  task automatic step(input string name, input logic c, input logic v, input logic [7:0] ch,
                      input logic eo, input logic [W-1:0] ev, input logic ee, input logic eov);
    clr = c; in_valid = v; in = ch;
    @(posedge clk);
    #1;
    total++;
    if (out !== eo || value !== ev || err !== ee || ovf !== eov) begin
      bad++;
      $display("FAIL %s: got out=%b value=%0d err=%b ovf=%b, need out=%b value=%0d err=%b ovf=%b",
               name, out, value, err, ovf, eo, ev, ee, eov);
    end
  endtask

  logic [7:0] seq_ch  [7] = '{"2", "*", "3", "*", "4", "+", "5"};
  logic       seq_out [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  int         seq_val [7] = '{2, 2, 6, 6, 24, 24, 29};

  initial begin
    clr = 1'b1; in_valid = 1'b0; in = 8'h00;

    // reset, then "1+2*3"
    add(1, 0, 8'h00, 0, 0, 0, 0);
    add(0, 1, "1", 1, 1, 0, 0);
    add(0, 1, "+", 0, 1, 0, 0);
    add(0, 1, "2", 1, 3, 0, 0);
    add(0, 1, "*", 0, 3, 0, 0);
    add(0, 1, "3", 1, 7, 0, 0);
    // leading operator
    add(1, 0, 8'h00, 0, 0, 0, 0);
    add(0, 1, "+", 0, 0, 1, 0);
    add(0, 1, "5", 0, 0, 1, 0);
    // two digits in a row
    add(1, 0, 8'h00, 0, 0, 0, 0);
    add(0, 1, "1", 1, 1, 0, 0);
    add(0, 1, "2", 0, 1, 1, 0);
    add(0, 1, "3", 0, 1, 1, 0);
    // illegal byte after a digit
    add(1, 0, 8'h00, 0, 0, 0, 0);
    add(0, 1, "3", 1, 3, 0, 0);
    add(0, 1, "-", 0, 3, 1, 0);
    add(0, 1, "4", 0, 3, 1, 0);
    // bytes just outside the digit range
    add(1, 0, 8'h00, 0, 0, 0, 0);
    add(0, 1, "/", 0, 0, 1, 0);
    add(1, 0, 8'h00, 0, 0, 0, 0);
    add(0, 1, ":", 0, 0, 1, 0);
    add(1, 0, 8'h00, 0, 0, 0, 0);
    add(0, 1, "*", 0, 0, 1, 0);
    // "9*9*9" wraps at 8 bits
    add(1, 0, 8'h00, 0, 0, 0, 0);
    add(0, 1, "9", 1, 9, 0, 0);
    add(0, 1, "*", 0, 9, 0, 0);
    add(0, 1, "9", 1, 81, 0, 0);
    add(0, 1, "*", 0, 81, 0, 0);
    add(0, 1, "9", 1, 217, 0, 1);
    add(0, 1, "+", 0, 217, 0, 1);
    // "9*9+9*9*9"
    add(1, 0, 8'h00, 0, 0, 0, 0);
    add(0, 1, "9", 1, 9, 0, 0);
    add(0, 1, "*", 0, 9, 0, 0);
    add(0, 1, "9", 1, 81, 0, 0);
    add(0, 1, "+", 0, 81, 0, 0);
    add(0, 1, "9", 1, 90, 0, 0);
    add(0, 1, "*", 0, 90, 0, 0);
    add(0, 1, "9", 1, 162, 0, 0);
    add(0, 1, "*", 0, 162, 0, 0);
    add(0, 1, "9", 1, 42, 0, 1);
    // sum carry with no product overflow: 9*9*3=243, +9 -> 252, +9 -> 261
    add(1, 0, 8'h00, 0, 0, 0, 0);
    add(0, 1, "9", 1, 9, 0, 0);
    add(0, 1, "*", 0, 9, 0, 0);
    add(0, 1, "9", 1, 81, 0, 0);
    add(0, 1, "*", 0, 81, 0, 0);
    add(0, 1, "3", 1, 243, 0, 0);
    add(0, 1, "+", 0, 243, 0, 0);
    add(0, 1, "9", 1, 252, 0, 0);
    add(0, 1, "+", 0, 252, 0, 0);
    add(0, 1, "9", 1, 5, 0, 1);
    // "1+" incomplete, gap, then "0"
    add(1, 0, 8'h00, 0, 0, 0, 0);
    add(0, 1, "1", 1, 1, 0, 0);
    add(0, 1, "+", 0, 1, 0, 0);
    add(0, 0, "9", 0, 1, 0, 0);
    add(0, 1, "0", 1, 1, 0, 0);
    // clr coincident with the final character of "5*5"
    add(1, 0, 8'h00, 0, 0, 0, 0);
    add(0, 1, "5", 1, 5, 0, 0);
    add(0, 1, "*", 0, 5, 0, 0);
    add(1, 1, "5", 0, 0, 0, 0);
    add(0, 1, "7", 1, 7, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("vec%0d", i), tbl[i].clr, tbl[i].vld, tbl[i].ch,
           tbl[i].e_out, tbl[i].e_val, tbl[i].e_err, tbl[i].e_ovf);
    end

    // "2*3*4+5" back-to-back, then again with 1-3 idle cycles between characters
    for (int pass = 0; pass < 2; pass++) begin
      step("seq_clr", 1, 0, 8'h00, 0, 0, 0, 0);
      for (int k = 0; k < 7; k++) begin
        step($sformatf("seq%0d_ch%0d", pass, k), 0, 1, seq_ch[k],
             seq_out[k], W'(seq_val[k]), 0, 0);
        if (pass == 1) begin
          for (int g = 0; g < 1 + (k % 3); g++)
            step($sformatf("seq_gap%0d_%0d", k, g), 0, 0, "9",
                 seq_out[k], W'(seq_val[k]), 0, 0);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
